// File: rtl/tta_move_ctrl.sv
// Move controller for a transport-triggered datapath: sequences one bus move at a time
// between functional units, or from an immediate value, over a shared tri-state bus.
module tta_move_ctrl #(
  parameter int N_UNITS = 4,
  parameter int WIDTH   = 24,
  localparam int IDX_W  = (N_UNITS > 1) ? $clog2(N_UNITS) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   mv_valid,
  output logic                   mv_ready,
  input  logic                   mv_imm,
  input  logic [WIDTH-1:0]       mv_data,
  input  logic [IDX_W-1:0]       mv_src,
  input  logic [IDX_W-1:0]       mv_dst,
  input  logic                   mv_port,
  output logic [3*N_UNITS-1:0]   op_sel,
  inout  wire  [WIDTH-1:0]       bus,
  output logic                   done,
  output logic                   err,
  output logic [WIDTH-1:0]       last_data
);

  localparam logic [2:0] SEL_LD_A = 3'b001;
  localparam logic [2:0] SEL_LD_B = 3'b010;
  localparam logic [2:0] SEL_OUT  = 3'b100;

  typedef enum logic [1:0] {
    S_IDLE,
    S_COMPUTE,
    S_TRANSFER,
    S_IMM
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   data_q, data_d;
  logic [IDX_W-1:0]   src_q, src_d;
  logic [IDX_W-1:0]   dst_q, dst_d;
  logic               port_q, port_d;
  logic               done_q, done_d;
  logic               err_q, err_d;
  logic [WIDTH-1:0]   last_q, last_d;

  function automatic logic idx_ok(input logic [IDX_W-1:0] idx);
    return 32'(idx) < 32'(N_UNITS);
  endfunction

  // Next-state: the IMM state itself stands in for the registered mv_imm flag.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    src_d   = src_q;
    dst_d   = dst_q;
    port_d  = port_q;
    err_d   = 1'b0;
    done_d  = (state_q == S_TRANSFER) || (state_q == S_IMM);
    last_d  = done_d ? bus : last_q;
    unique case (state_q)
      S_IDLE: begin
        if (mv_valid) begin
          data_d = mv_data;
          src_d  = mv_src;
          dst_d  = mv_dst;
          port_d = mv_port;
          if (mv_imm) begin
            if (idx_ok(mv_dst)) state_d = S_IMM;
            else                err_d   = 1'b1;
          end else if (idx_ok(mv_src) && idx_ok(mv_dst) && (mv_src != mv_dst)) begin
            state_d = S_COMPUTE;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_COMPUTE:  state_d = S_TRANSFER;
      S_TRANSFER: state_d = S_IDLE;
      S_IMM:      state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      last_q  <= '0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
      err_q   <= err_d;
      last_q  <= last_d;
    end
  end

  // Move fields are only meaningful after acceptance, so they carry no reset.
  always_ff @(posedge clk) begin
    data_q <= data_d;
    src_q  <= src_d;
    dst_q  <= dst_d;
    port_q <= port_d;
  end

  // Source keeps SEL_OUT through TRANSFER so its fresh result stays on the bus.
  always_comb begin
    op_sel = '0;
    for (int k = 0; k < N_UNITS; k++) begin
      if (((state_q == S_COMPUTE) || (state_q == S_TRANSFER)) && (int'(src_q) == k))
        op_sel[3*k +: 3] = SEL_OUT;
      if (((state_q == S_TRANSFER) || (state_q == S_IMM)) && (int'(dst_q) == k))
        op_sel[3*k +: 3] = port_q ? SEL_LD_B : SEL_LD_A;
    end
  end

  assign bus       = (state_q == S_IMM) ? data_q : {WIDTH{1'bz}};
  assign mv_ready  = (state_q == S_IDLE);
  assign done      = done_q;
  assign err       = err_q;
  assign last_data = last_q;

endmodule

// File: tb/tb_tta_move_ctrl.sv
// Bench for tta_move_ctrl with four behavioural units on the bus:
// u0 adder, u1 subtractor (A-B), u2 pass A, u3 A&B.
module tb_tta_move_ctrl;
  localparam int N = 4;
  localparam int W = 24;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic           mv_valid, mv_imm, mv_port;
  logic [W-1:0]   mv_data;
  logic [1:0]     mv_src, mv_dst;
  logic           mv_ready, done, err;
  logic [3*N-1:0] op_sel;
  logic [W-1:0]   last_data;
  tri   [W-1:0]   bus;

  int n_cmp = 0;
  int n_bad = 0;

  tta_move_ctrl #(.N_UNITS(N), .WIDTH(W)) dut (
    .clk(clk), .rst(rst), .mv_valid(mv_valid), .mv_ready(mv_ready),
    .mv_imm(mv_imm), .mv_data(mv_data), .mv_src(mv_src), .mv_dst(mv_dst),
    .mv_port(mv_port), .op_sel(op_sel), .bus(bus), .done(done), .err(err),
    .last_data(last_data)
  );

  always #5 clk = ~clk;

  logic [W-1:0] ua [N];
  logic [W-1:0] ub [N];
  logic [W-1:0] ur [N];

  function automatic logic [W-1:0] unit_fn(input int k, input logic [W-1:0] a, input logic [W-1:0] b);
    case (k)
      0:       return a + b;
      1:       return a - b;
      2:       return a;
      default: return a & b;
    endcase
  endfunction

  always @(posedge clk) begin
    for (int k = 0; k < N; k++) begin
      case (op_sel[3*k +: 3])
        3'b001:  ua[k] <= bus;
        3'b010:  ub[k] <= bus;
        3'b100:  ur[k] <= unit_fn(k, ua[k], ub[k]);
        default: ;
      endcase
    end
  end

  genvar g;
  for (g = 0; g < N; g++) begin : g_unit_drv
    assign bus = (op_sel[3*g +: 3] == 3'b100) ? ur[g] : {W{1'bz}};
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_true(input string name, input logic cond, input logic [31:0] act);
    n_cmp++;
    if (cond !== 1'b1) begin
      n_bad++;
      $display("FAIL %s: observed %0h", name, act);
    end
  endtask

  function automatic logic [3*N-1:0] sel_of(input int u, input logic [2:0] code);
    logic [3*N-1:0] r;
    r = '0;
    r[3*u +: 3] = code;
    return r;
  endfunction

  typedef struct {
    logic         imm;
    logic [W-1:0] data;
    int           src;
    int           dst;
    logic         port;
    logic         rej;
    logic [W-1:0] exp_last;
  } vec_t;

  vec_t vecs [13];

  task automatic run_move(input vec_t v);
    logic [2:0] ld;
    ld = v.port ? 3'b010 : 3'b001;
    @(posedge clk); #1;
    check("idle_ready", mv_ready, 1'b1);
    check("idle_done_low", done, 1'b0);
    mv_valid = 1'b1;
    mv_imm   = v.imm;
    mv_data  = v.data;
    mv_src   = 2'(v.src);
    mv_dst   = 2'(v.dst);
    mv_port  = v.port;
    @(posedge clk); #1;
    mv_valid = 1'b0;
    mv_data  = ~v.data;
    mv_src   = 2'(v.dst);
    mv_dst   = 2'(v.src);
    mv_port  = ~v.port;
    mv_imm   = ~v.imm;
    if (v.rej) begin
      check("rej_err", err, 1'b1);
      check("rej_opsel", op_sel, '0);
      check("rej_done", done, 1'b0);
      check("rej_ready", mv_ready, 1'b1);
      @(posedge clk); #1;
      check("rej_err_once", err, 1'b0);
      check("rej_last_kept", last_data, v.exp_last);
    end else if (v.imm) begin
      check("imm_opsel", op_sel, sel_of(v.dst, ld));
      check("imm_bus", bus, v.data);
      check("imm_ready", mv_ready, 1'b0);
      @(posedge clk); #1;
      check("imm_done", done, 1'b1);
      check("imm_last", last_data, v.exp_last);
      check("imm_opsel_idle", op_sel, '0);
    end else begin
      check("cmp_opsel", op_sel, sel_of(v.src, 3'b100));
      check("cmp_ready", mv_ready, 1'b0);
      @(posedge clk); #1;
      check("xfr_opsel", op_sel, sel_of(v.src, 3'b100) | sel_of(v.dst, ld));
      check("xfr_done", done, 1'b0);
      check("xfr_bus", bus, v.exp_last);
      @(posedge clk); #1;
      check("unit_done", done, 1'b1);
      check("unit_last", last_data, v.exp_last);
      check("unit_opsel_idle", op_sel, '0);
      check("unit_ready", mv_ready, 1'b1);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int er [7];
    int ed [7];
    int acc [2];
    int n_acc;
    int n_done;

    mv_valid = 1'b0; mv_imm = 1'b0; mv_data = '0;
    mv_src = '0; mv_dst = '0; mv_port = 1'b0;

    //          imm   data         src dst port rej  exp_last
    vecs[0]  = '{1'b1, 24'd5,       0, 0, 1'b0, 1'b0, 24'd5};
    vecs[1]  = '{1'b1, 24'd7,       0, 0, 1'b1, 1'b0, 24'd7};
    vecs[2]  = '{1'b0, 24'd0,       0, 2, 1'b0, 1'b0, 24'd12};
    vecs[3]  = '{1'b1, 24'hFFFFFF,  0, 0, 1'b0, 1'b0, 24'hFFFFFF};
    vecs[4]  = '{1'b1, 24'h000001,  0, 0, 1'b1, 1'b0, 24'h000001};
    vecs[5]  = '{1'b0, 24'd0,       0, 1, 1'b0, 1'b0, 24'h000000};
    vecs[6]  = '{1'b1, 24'd3,       0, 1, 1'b0, 1'b0, 24'd3};
    vecs[7]  = '{1'b1, 24'd5,       0, 1, 1'b1, 1'b0, 24'd5};
    vecs[8]  = '{1'b0, 24'd0,       1, 0, 1'b1, 1'b0, 24'hFFFFFE};
    vecs[9]  = '{1'b0, 24'd0,       2, 2, 1'b0, 1'b1, 24'hFFFFFE};
    vecs[10] = '{1'b0, 24'd0,       2, 3, 1'b1, 1'b0, 24'd12};
    vecs[11] = '{1'b1, 24'h123456,  0, 3, 1'b0, 1'b0, 24'h123456};
    vecs[12] = '{1'b0, 24'd0,       3, 2, 1'b1, 1'b0, 24'h000004};

    #1 rst = 1'b1;
    #2;
    check("rst_opsel", op_sel, '0);
    check("rst_done", done, 1'b0);
    check("rst_err", err, 1'b0);
    check("rst_last", last_data, '0);
    check("rst_ready", mv_ready, 1'b1);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    for (int i = 0; i < 13; i++) run_move(vecs[i]);

    // Back-to-back unit moves u0->u2.A with mv_valid held high
    er = '{1, 0, 0, 1, 0, 0, 1};
    ed = '{0, 0, 0, 1, 0, 0, 1};
    n_acc = 0;
    n_done = 0;
    acc = '{0, 0};
    @(posedge clk); #1;
    mv_valid = 1'b1; mv_imm = 1'b0; mv_src = 2'd0; mv_dst = 2'd2; mv_port = 1'b0;
    for (int c = 0; c < 7; c++) begin
      if (c > 0) begin
        @(posedge clk); #1;
      end
      check("b2b_ready", mv_ready, er[c][0]);
      check("b2b_done", done, ed[c][0]);
      if (done) n_done++;
      if (c == 6) mv_valid = 1'b0;
      if (mv_valid && mv_ready) begin
        if (n_acc < 2) acc[n_acc] = c;
        n_acc++;
      end
      mv_data = W'($urandom);
    end
    check("b2b_accepts", n_acc, 2);
    check("b2b_spacing", acc[1] - acc[0], 3);
    check("b2b_done_count", n_done, 2);
    check("b2b_last", last_data, 24'hFFFFFD);
    @(posedge clk); #1;
    check("b2b_no_extra", op_sel, '0);

    // Reset while in TRANSFER, u0->u3.A
    mv_valid = 1'b1; mv_imm = 1'b0; mv_src = 2'd0; mv_dst = 2'd3; mv_port = 1'b0;
    @(posedge clk); #1;
    mv_valid = 1'b0;
    @(posedge clk); #1;
    check("rx_opsel_pre", op_sel, sel_of(0, 3'b100) | sel_of(3, 3'b001));
    check("rx_bus_pre", bus, 24'hFFFFFD);
    #2 rst = 1'b1;
    #1;
    check("rx_opsel", op_sel, '0);
    check_true("rx_bus_released", bus !== 24'hFFFFFD, bus);
    check("rx_ready", mv_ready, 1'b1);
    check("rx_done", done, 1'b0);
    check("rx_last", last_data, '0);
    @(posedge clk); #1;
    check("rx_done_hold", done, 1'b0);
    #2 rst = 1'b0;
    #1 check("rx_ready_rel", mv_ready, 1'b1);
    @(posedge clk); #1;
    check("rx_no_done", done, 1'b0);
    check("rx_last_after", last_data, '0);

    // Reset while in IMM, A5A5A5->u1.B
    mv_valid = 1'b1; mv_imm = 1'b1; mv_data = 24'hA5A5A5; mv_dst = 2'd1; mv_port = 1'b1;
    @(posedge clk); #1;
    mv_valid = 1'b0;
    check("ri_bus_pre", bus, 24'hA5A5A5);
    check("ri_opsel_pre", op_sel, sel_of(1, 3'b010));
    #2 rst = 1'b1;
    #1;
    check_true("ri_bus_released", bus !== 24'hA5A5A5, bus);
    check("ri_opsel", op_sel, '0);
    #3 rst = 1'b0;
    @(posedge clk); #1;
    check("ri_no_done", done, 1'b0);
    check("ri_ready", mv_ready, 1'b1);
    check("ri_last", last_data, '0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/tta_move_ctrl.md
TTA_MOVE_CTRL -- requirements
Module: tta_move_ctrl

Interface
REQ-001 SHALL have parameter N_UNITS, default 4, number of bus-attached functional units.
REQ-002 SHALL have parameter WIDTH, default 24, shared bus width.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port mv_valid  input  1  move request present.
REQ-006 SHALL have port mv_ready  output  1  move request accepted when mv_valid && mv_ready at a rising edge.
REQ-007 SHALL have port mv_imm  input  1  1 = immediate move (controller drives mv_data); 0 = unit-to-unit move.
REQ-008 SHALL have port mv_data  input  WIDTH  immediate value, used only when mv_imm=1.
REQ-009 SHALL have port mv_src  input  clog2(N_UNITS)  source unit index, used only when mv_imm=0.
REQ-010 SHALL have port mv_dst  input  clog2(N_UNITS)  destination unit index.
REQ-011 SHALL have port mv_port  input  1  destination operand: 0 = operand A, 1 = operand B.
REQ-012 SHALL have port op_sel  output  3*N_UNITS  per-unit select; unit k owns bits [3k+2:3k].
REQ-013 SHALL have port bus  inout  WIDTH  shared tri-state operand/result bus.
REQ-014 SHALL have port done  output  1  one-cycle pulse per completed move.
REQ-015 SHALL have port err  output  1  one-cycle pulse per rejected move.
REQ-016 SHALL have port last_data  output  WIDTH  bus value captured by the last completed move.

Function
REQ-017 SHALL use op_sel codes 3'b000 idle, 3'b001 load A, 3'b010 load B, 3'b100 output result; every other unit SHALL see 3'b000.
REQ-018 SHALL implement states IDLE, COMPUTE, TRANSFER, IMM; mv_ready=1 only in IDLE.
REQ-019 SHALL, on acceptance, register mv_imm/mv_data/mv_src/mv_dst/mv_port; later input changes have no effect.
REQ-020 SHALL transition IDLE->IMM on an accepted move with mv_imm=1, and IDLE->COMPUTE on an accepted move with mv_imm=0 and mv_src!=mv_dst.
REQ-021 SHALL, on an accepted move with mv_imm=0 and mv_src==mv_dst, stay in IDLE, drive no op_sel, and pulse err in the next cycle.
REQ-022 SHALL, in COMPUTE (1 cycle), drive op_sel[src]=3'b100 and all others 3'b000, since the unit result register updates on this edge; then go to TRANSFER.
REQ-023 SHALL, in TRANSFER (1 cycle), hold op_sel[src]=3'b100 and drive op_sel[dst]=3'b001/3'b010 per the port, then return to IDLE.
REQ-024 SHALL, in IMM (1 cycle), drive bus=registered mv_data and op_sel[dst]=load code per the port, then return to IDLE.
REQ-025 SHALL drive bus only in IMM; the bus SHALL be high-Z in all other states.
REQ-026 SHALL, at the edge ending TRANSFER or IMM, capture bus into last_data and pulse done in the following cycle (coincident with IDLE).
REQ-027 SHALL complete unit moves in 3 cycles from acceptance to the next acceptance, and immediate moves in 2 cycles.
REQ-028 SHALL treat data as unsigned WIDTH bits; the controller does no arithmetic and no wrap handling beyond the units' own modulo-2^WIDTH results.
REQ-029 SHALL, while mv_valid stays high continuously, accept exactly one move per IDLE visit and no move in other states.
REQ-030 SHALL ignore out-of-range mv_src/mv_dst (>= N_UNITS) by rejecting them as in REQ-021.

Reset
REQ-031 SHALL, while rst=1, immediately force state IDLE, op_sel all 0, bus high-Z, done=0, err=0, and last_data=0, independent of clk.
REQ-032 SHALL abandon an in-flight move on reset with no done pulse; mv_ready=1 in the first cycle after rst falls.

Verification
REQ-033 SHALL verify a basic unit move with unit0=adder: imm 5->u0.A, imm 7->u0.B, move u0->u2.A -> done after 3 cycles, last_data=24'd12, op_sel[2]=001 only in TRANSFER.
REQ-034 SHALL verify adder wrap: imm FFFFFF->u0.A, imm 000001->u0.B, move u0->u1.A -> last_data=24'h000000.
REQ-035 SHALL verify subtractor underflow with unit1=subtractor: 3->u1.A, 5->u1.B, move u1->u0.B -> last_data=24'hFFFFFE.
REQ-036 SHALL verify rejection: move with mv_src=mv_dst=2 -> err pulses once, op_sel stays 0, done stays 0, mv_ready stays 1.
REQ-037 SHALL verify reset in TRANSFER: assert rst mid-cycle -> op_sel=0 and bus=Z without waiting for a clock edge, no done, mv_ready=1 after release.
REQ-038 SHALL verify back-to-back moves with mv_valid held high for 2 unit moves -> acceptances exactly 3 cycles apart, two done pulses.
